// File: rtl/alu_issue.sv
// alu_issue: accepts one decoded OP / OP-IMM instruction at a time, drives the
// operands to a multi-cycle ALU, waits (bounded by TIMEOUT) for completion and
// returns the result, rd and status flags through a valid/ready response.
module alu_issue #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // request side
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rs1Val_i,
  input  logic [31:0] rs2Val_i,
  input  logic [31:0] imm_i,
  // ALU side
  output logic [31:0] aluArg1_o,
  output logic [31:0] aluArg2_o,
  output logic [2:0]  aluFunct3_o,
  output logic        aluSubSr_o,
  output logic        aluStart_o,
  input  logic [31:0] aluRes_i,
  input  logic        aluDone_i,
  // response side
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rspRes_o,
  output logic [4:0]  rspRd_o,
  output logic        rspIllegal_o,
  output logic        rspTimeout_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  // Last WAIT count value; reaching it without done ends the wait.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Only register-register and register-immediate ALU ops are handled here.
  function automatic logic is_alu_op(input logic [6:0] opc);
    is_alu_op = (opc == OPC_OP) || (opc == OPC_OP_IMM);
  endfunction

  // funct7 bit 5 selects sub/sra for OP, but only sra (srai) for OP-IMM:
  // for addi the bit is part of the immediate and must not mean subtract.
  function automatic logic dec_sub_sr(input logic [6:0] opc,
                                      input logic [2:0] f3,
                                      input logic       f7b5);
    logic r;
    if (opc == OPC_OP) begin
      r = f7b5 & ((f3 == 3'b000) || (f3 == 3'b101));
    end else if (opc == OPC_OP_IMM) begin
      r = f7b5 & (f3 == 3'b101);
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        alu_start_q, alu_start_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] alu_arg1_q, alu_arg1_d;
  logic [31:0] alu_arg2_q, alu_arg2_d;
  logic [2:0]  alu_funct3_q, alu_funct3_d;
  logic        alu_sub_sr_q, alu_sub_sr_d;
  logic [31:0] rsp_res_q, rsp_res_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        transfer_s;

  // req_ready_q is only ever high in IDLE, so this is the full transfer condition.
  assign transfer_s = req_valid_i & req_ready_q;

  // Next-state, operand capture, wait counter and response payload.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_arg1_d    = alu_arg1_q;
    alu_arg2_d    = alu_arg2_q;
    alu_funct3_d  = alu_funct3_q;
    alu_sub_sr_d  = alu_sub_sr_q;
    rsp_res_d     = rsp_res_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (transfer_s) begin
          rsp_rd_d      = rd_i;
          rsp_res_d     = 32'd0;
          rsp_timeout_d = 1'b0;
          if (is_alu_op(opcode_i)) begin
            alu_arg1_d    = rs1Val_i;
            alu_arg2_d    = (opcode_i == OPC_OP) ? rs2Val_i : imm_i;
            alu_funct3_d  = funct3_i;
            alu_sub_sr_d  = dec_sub_sr(opcode_i, funct3_i, funct7b5_i);
            rsp_illegal_d = 1'b0;
            state_d       = ST_ISSUE;
          end else begin
            // Unsupported opcode: answer straight away, the ALU is never started.
            alu_arg1_d    = 32'd0;
            alu_arg2_d    = 32'd0;
            alu_funct3_d  = 3'd0;
            alu_sub_sr_d  = 1'b0;
            rsp_illegal_d = 1'b1;
            state_d       = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (aluDone_i) begin
          // Done wins even on the edge where the timeout would fire.
          rsp_res_d = aluRes_i;
          state_d   = ST_RESP;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          rsp_res_d     = 32'd0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake/strobe outputs are registered images of the next state.
    req_ready_d = (state_d == ST_IDLE);
    alu_start_d = (state_d == ST_ISSUE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      req_ready_q   <= 1'b0;
      alu_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      alu_arg1_q    <= 32'd0;
      alu_arg2_q    <= 32'd0;
      alu_funct3_q  <= 3'd0;
      alu_sub_sr_q  <= 1'b0;
      rsp_res_q     <= 32'd0;
      rsp_rd_q      <= 5'd0;
      rsp_illegal_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      alu_start_q   <= alu_start_d;
      rsp_valid_q   <= rsp_valid_d;
      alu_arg1_q    <= alu_arg1_d;
      alu_arg2_q    <= alu_arg2_d;
      alu_funct3_q  <= alu_funct3_d;
      alu_sub_sr_q  <= alu_sub_sr_d;
      rsp_res_q     <= rsp_res_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign aluStart_o   = alu_start_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign aluArg1_o    = alu_arg1_q;
  assign aluArg2_o    = alu_arg2_q;
  assign aluFunct3_o  = alu_funct3_q;
  assign aluSubSr_o   = alu_sub_sr_q;
  assign rspRes_o     = rsp_res_q;
  assign rspRd_o      = rsp_rd_q;
  assign rspIllegal_o = rsp_illegal_q;
  assign rspTimeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, randomized transactions checked
// against a rule-level model, and hand-written reset/backpressure sequences.
module tb_alu_issue;
  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [6:0]  opcode_i = 7'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic        funct7b5_i = 1'b0;
  logic [4:0]  rd_i = 5'd0;
  logic [31:0] rs1Val_i = 32'd0, rs2Val_i = 32'd0, imm_i = 32'd0;
  logic [31:0] aluArg1_o, aluArg2_o;
  logic [2:0]  aluFunct3_o;
  logic        aluSubSr_o, aluStart_o;
  logic [31:0] aluRes_i = 32'd0;
  logic        aluDone_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rspRes_o;
  logic [4:0]  rspRd_o;
  logic        rspIllegal_o, rspTimeout_o;

  alu_issue #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i), .rd_i(rd_i),
    .rs1Val_i(rs1Val_i), .rs2Val_i(rs2Val_i), .imm_i(imm_i),
    .aluArg1_o(aluArg1_o), .aluArg2_o(aluArg2_o), .aluFunct3_o(aluFunct3_o),
    .aluSubSr_o(aluSubSr_o), .aluStart_o(aluStart_o),
    .aluRes_i(aluRes_i), .aluDone_i(aluDone_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rspRes_o(rspRes_o), .rspRd_o(rspRd_o),
    .rspIllegal_o(rspIllegal_o), .rspTimeout_o(rspTimeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2, imm, alu_res;
    int          done_at;     // WAIT edge (1-based) carrying done; > TO means never
    int          ready_delay; // cycles of rsp_ready_i=0 in RESP
    logic [31:0] e_arg1, e_arg2;
    logic [2:0]  e_f3;
    logic        e_sub, e_ill, e_to;
    logic [31:0] e_res;
    int          e_lat;       // edges from transfer (counted as 1) to rsp_valid_o
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model built from the instruction rules and a latency formula.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit op  = (v.opcode == 7'b0110011);
    bit imm = (v.opcode == 7'b0010011);
    r.e_ill  = !(op || imm);
    r.e_arg1 = v.rs1;
    r.e_arg2 = op ? v.rs2 : v.imm;
    r.e_f3   = v.funct3;
    if (op) r.e_sub = v.f7b5 && (v.funct3 == 3'd0 || v.funct3 == 3'd5);
    else    r.e_sub = v.f7b5 && (v.funct3 == 3'd5);
    r.e_to  = !r.e_ill && (v.done_at > int'(TO));
    r.e_res = (r.e_ill || r.e_to) ? 32'd0 : v.alu_res;
    if (r.e_ill)     r.e_lat = 1;
    else if (r.e_to) r.e_lat = 2 + int'(TO);
    else             r.e_lat = 2 + v.done_at;
    return r;
  endfunction

  // One full transaction: offer, track ISSUE/WAIT, check response, backpressure, handshake.
  task automatic run_txn(input vec_t v, input string tag);
    int k;
    bit seen;
    k = 0;
    while (req_ready_o !== 1'b1 && k < 10) begin
      @(negedge clk_i);
      k++;
    end
    check({tag, " req_ready before"}, 32'(req_ready_o), 32'd1);
    opcode_i = v.opcode; funct3_i = v.funct3; funct7b5_i = v.f7b5; rd_i = v.rd;
    rs1Val_i = v.rs1; rs2Val_i = v.rs2; imm_i = v.imm;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    opcode_i = 7'($urandom); funct3_i = 3'($urandom); funct7b5_i = 1'($urandom);
    rd_i = 5'($urandom); rs1Val_i = $urandom; rs2Val_i = $urandom; imm_i = $urandom;
    k = 1;
    seen = 1'b0;
    while (k <= 20 && !seen) begin
      if (rsp_valid_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        check({tag, " aluStart"}, 32'(aluStart_o), 32'(!v.e_ill && k == 1));
        check({tag, " req_ready busy"}, 32'(req_ready_o), 32'd0);
        if (!v.e_ill) begin
          check({tag, " arg1"}, aluArg1_o, v.e_arg1);
          check({tag, " arg2"}, aluArg2_o, v.e_arg2);
          check({tag, " funct3"}, 32'(aluFunct3_o), 32'(v.e_f3));
          check({tag, " subSr"}, 32'(aluSubSr_o), 32'(v.e_sub));
        end
        // Spurious done during ISSUE must be ignored.
        aluDone_i = (k == 1) || (k == 1 + v.done_at);
        aluRes_i  = (k == 1 + v.done_at) ? v.alu_res : $urandom;
        @(posedge clk_i);
        @(negedge clk_i);
        aluDone_i = 1'b0;
        k++;
      end
    end
    check({tag, " rsp seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(k), 32'(v.e_lat));
    check({tag, " rspRes"}, rspRes_o, v.e_res);
    check({tag, " rspRd"}, 32'(rspRd_o), 32'(v.rd));
    check({tag, " illegal"}, 32'(rspIllegal_o), 32'(v.e_ill));
    check({tag, " timeout"}, 32'(rspTimeout_o), 32'(v.e_to));
    check({tag, " aluStart in resp"}, 32'(aluStart_o), 32'd0);
    for (int b = 0; b < v.ready_delay; b++) begin
      rsp_ready_i = 1'b0;
      aluDone_i = 1'b1;
      aluRes_i = $urandom;
      @(posedge clk_i);
      @(negedge clk_i);
      aluDone_i = 1'b0;
      check({tag, " bp valid"}, 32'(rsp_valid_o), 32'd1);
      check({tag, " bp res"}, rspRes_o, v.e_res);
      check({tag, " bp rd"}, 32'(rspRd_o), 32'(v.rd));
      check({tag, " bp flags"}, 32'({rspIllegal_o, rspTimeout_o}), 32'({v.e_ill, v.e_to}));
      check({tag, " bp req_ready"}, 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check({tag, " valid after hs"}, 32'(rsp_valid_o), 32'd0);
    check({tag, " ready after hs"}, 32'(req_ready_o), 32'd1);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // opcode, f3, f7b5, rd, rs1, rs2, imm, alu_res, done_at, ready_delay,
    // e_arg1, e_arg2, e_f3, e_sub, e_ill, e_to, e_res, e_lat
    tbl[0] = '{7'b0110011, 3'd0, 1'b1, 5'd5, 32'd10, 32'd3, 32'h1234, 32'd7, 2, 5,
               32'd10, 32'd3, 3'd0, 1'b1, 1'b0, 1'b0, 32'd7, 4};
    tbl[1] = '{7'b0010011, 3'd0, 1'b1, 5'd9, 32'h100, 32'h55, 32'hFFFFFFFF, 32'hFF, 1, 0,
               32'h100, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFF, 3};
    tbl[2] = '{7'b0010011, 3'd5, 1'b1, 5'd1, 32'h80000000, 32'h9, 32'd3, 32'hF0000000, 3, 1,
               32'h80000000, 32'd3, 3'd5, 1'b1, 1'b0, 1'b0, 32'hF0000000, 5};
    tbl[3] = '{7'b0110011, 3'd1, 1'b1, 5'd2, 32'd1, 32'd4, 32'd0, 32'd16, 1, 0,
               32'd1, 32'd4, 3'd1, 1'b0, 1'b0, 1'b0, 32'd16, 3};
    tbl[4] = '{7'b1100011, 3'd0, 1'b0, 5'd7, 32'd1, 32'd2, 32'd3, 32'd99, 1, 2,
               32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1};
    tbl[5] = '{7'b0110011, 3'd0, 1'b0, 5'd12, 32'd8, 32'd8, 32'd0, 32'hDEAD, 100, 0,
               32'd8, 32'd8, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0, 6};
    tbl[6] = '{7'b0110011, 3'd0, 1'b0, 5'd13, 32'd8, 32'd9, 32'd0, 32'hABCD, 4, 0,
               32'd8, 32'd9, 3'd0, 1'b0, 1'b0, 1'b0, 32'hABCD, 6};
    tbl[7] = '{7'b0010011, 3'd7, 1'b1, 5'd0, 32'hF0F0, 32'd0, 32'h0FF0, 32'h00F0, 2, 1,
               32'hF0F0, 32'h0FF0, 3'd7, 1'b0, 1'b0, 1'b0, 32'h00F0, 4};
    tbl[8] = '{7'b0110011, 3'd5, 1'b0, 5'd31, 32'h80, 32'd2, 32'd0, 32'h20, 1, 0,
               32'h80, 32'd2, 3'd5, 1'b0, 1'b0, 1'b0, 32'h20, 3};

    // Reset state.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst req_ready", 32'(req_ready_o), 32'd0);
    check("rst aluStart", 32'(aluStart_o), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst data", aluArg1_o | aluArg2_o | rspRes_o, 32'd0);
    check("rst fields", 32'({aluFunct3_o, aluSubSr_o, rspRd_o, rspIllegal_o, rspTimeout_o}), 32'd0);
    rst_i = 1'b1;
    #1;
    check("rst release ready before edge", 32'(req_ready_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst release ready", 32'(req_ready_o), 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while waiting on the ALU.
    opcode_i = 7'b0110011; funct3_i = 3'd5; funct7b5_i = 1'b1; rd_i = 5'd3;
    rs1Val_i = 32'h11; rs2Val_i = 32'h22; imm_i = 32'h33;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst wait sub", 32'(aluSubSr_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("midrst async data", aluArg1_o | aluArg2_o | rspRes_o, 32'd0);
    check("midrst async fields", 32'({aluFunct3_o, aluSubSr_o, rspRd_o, rspIllegal_o, rspTimeout_o}), 32'd0);
    check("midrst async strobes", 32'({req_ready_o, aluStart_o, rsp_valid_o}), 32'd0);
    aluDone_i = 1'b1;
    aluRes_i = 32'h5555;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    aluDone_i = 1'b0;
    check("midrst held", 32'({req_ready_o, aluStart_o, rsp_valid_o}), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst release ready", 32'(req_ready_o), 32'd1);
    check("midrst no rsp", 32'(rsp_valid_o), 32'd0);
    run_txn(tbl[0], "post-reset");

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      rv = tbl[0];
      case ($urandom_range(0, 3))
        0: rv.opcode = 7'b0110011;
        1: rv.opcode = 7'b0010011;
        2: rv.opcode = 7'b0110011;
        default: rv.opcode = 7'($urandom);
      endcase
      rv.funct3 = 3'($urandom);
      rv.f7b5 = 1'($urandom);
      rv.rd = 5'($urandom);
      rv.rs1 = $urandom;
      rv.rs2 = $urandom;
      rv.imm = $urandom;
      rv.alu_res = $urandom;
      rv.done_at = $urandom_range(1, 6);
      rv.ready_delay = $urandom_range(0, 2);
      rv = model(rv);
      run_txn(rv, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, the maximum number of WAIT cycles before abort (legal range 2..255).
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid_i  input  1  decoded instruction offered.
REQ-005 SHALL have port req_ready_o  output  1  block accepts the instruction.
REQ-006 SHALL have ports opcode_i input 7, funct3_i input 3, funct7b5_i input 1, rd_i input 5  instruction fields.
REQ-007 SHALL have ports rs1Val_i, rs2Val_i, imm_i  input  32 each  operand values.
REQ-008 SHALL have ports aluArg1_o, aluArg2_o output 32, aluFunct3_o output 3, aluSubSr_o output 1  ALU operation.
REQ-009 SHALL have port aluStart_o  output  1  one-cycle pulse launching the ALU.
REQ-010 SHALL have ports aluRes_i input 32, aluDone_i input 1  ALU result and completion.
REQ-011 SHALL have ports rsp_valid_o output 1, rsp_ready_i input 1  writeback handshake.
REQ-012 SHALL have ports rspRes_o output 32, rspRd_o output 5, rspIllegal_o output 1, rspTimeout_o output 1  response payload.

Function
REQ-013 SHALL implement the states IDLE, ISSUE, WAIT, RESP.
REQ-014 SHALL drive req_ready_o=1 only in IDLE; a transfer occurs when req_valid_i and req_ready_o are both high on a clock edge.
REQ-015 SHALL register all request fields on the transfer edge and hold aluArg*/aluFunct3_o/aluSubSr_o stable from ISSUE until WAIT exits.
REQ-016 SHALL decode opcode 0110011 (OP) as arg1=rs1Val, arg2=rs2Val, subSr=funct7b5 when funct3 is 000 or 101, otherwise 0.
REQ-017 SHALL decode opcode 0010011 (OP-IMM) as arg1=rs1Val, arg2=imm, subSr=funct7b5 only when funct3=101, otherwise 0; funct3 is always passed through.
REQ-018 SHALL, for any other opcode, go IDLE->RESP directly with rspIllegal_o=1, rspRes_o=0, and no aluStart_o pulse.
REQ-019 SHALL pulse aluStart_o high for exactly the single ISSUE cycle, then enter WAIT.
REQ-020 SHALL ignore aluDone_i in IDLE, ISSUE and RESP.
REQ-021 SHALL, in WAIT, on the first edge with aluDone_i=1, capture aluRes_i into rspRes_o and enter RESP.
REQ-022 SHALL count WAIT cycles with an 8-bit counter cleared on ISSUE, and on reaching TIMEOUT without done SHALL enter RESP with rspTimeout_o=1 and rspRes_o=0; done on that same edge wins, with no timeout.
REQ-023 SHALL give a best-case latency of 3 edges from transfer to rsp_valid_o (transfer, ISSUE, done in the first WAIT cycle).
REQ-024 SHALL hold rsp_valid_o=1 and the payload stable in RESP until rsp_ready_i=1, then return to IDLE on that edge.
REQ-025 SHALL drive rspRd_o from the captured rd, including rd=0; the writeback stage discards rd=0.
REQ-026 SHALL accept the next request no earlier than the cycle after the response handshake (no overlap).
REQ-027 SHALL clear rspIllegal_o and rspTimeout_o on every new transfer.

Reset
REQ-028 SHALL, while rst_i=0, force IDLE, req_ready_o=0, aluStart_o=0, rsp_valid_o=0, all data outputs 0, flags 0 and counter 0.
REQ-029 SHALL, on rst_i asserting mid-operation, abandon the operation immediately with no response issued and no aluStart_o pulse.
REQ-030 SHALL leave reset with req_ready_o=1 on the first clock edge after rst_i rises.

Verification
REQ-031 OP sub: rs1=10, rs2=3, funct3=000, funct7b5=1 -> aluSubSr_o=1, arg2=3; done after 2 WAIT cycles, aluRes_i=7 -> rspRes_o=7, rd echoed.
REQ-032 OP-IMM addi: imm=0xFFFFFFFF, funct7b5=1, funct3=000 -> aluSubSr_o=0, aluArg2_o=0xFFFFFFFF; srai, funct3=101 -> aluSubSr_o=1.
REQ-033 Illegal opcode 1100011 -> rsp_valid_o 1 edge after transfer, rspIllegal_o=1, aluStart_o never pulses.
REQ-034 No done for TIMEOUT=4 -> rspTimeout_o=1, rspRes_o=0; repeat with done on the 4th WAIT edge -> result taken, no timeout.
REQ-035 Backpressure rsp_ready_i=0 for 5 cycles -> payload stable, req_ready_o=0; a spurious aluDone_i in RESP leaves rspRes_o unchanged.
REQ-036 rst_i pulled low in WAIT -> all outputs 0 asynchronously; after release, req_ready_o=1 and a fresh request completes normally.
